// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: byte write handshake into the transmit FIFO
interface uart_tx_buffered_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, output tx_valid, input tx_ready);
  modport slave(input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter
module uart_tx_buffered #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_buffered_if.slave tx_if,
  output logic TxD,
  output logic TxD_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CPB);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  logic txd_q, txd_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic push, pop, tick, nonempty, shift_en;
  assign nonempty = count_q != '0;
  assign tick = baud_q == BAUD_LAST;
  assign tx_if.tx_ready = count_q != FULL;
  assign push = tx_if.tx_valid && tx_if.tx_ready;
  assign pop = nonempty && (state_q == IDLE || (state_q == STOP && tick));
  assign shift_en = state_q == DATA && tick;
  assign TxD = txd_q;
  assign TxD_busy = state_q != IDLE || nonempty;
  assign fifo_count = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      txd_q <= txd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_if.tx_data;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = nonempty ? START : IDLE;
      START: state_d = tick ? DATA : START;
      DATA: state_d = (tick && bit_q == 3'd7) ? STOP : DATA;
      STOP: state_d = tick ? (nonempty ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    baud_d = (pop || tick || state_q == IDLE) ? '0 : baud_q + BW'(1);
    bit_d = pop ? 3'd0 : shift_en ? bit_q + 3'd1 : bit_q;
    shift_d = pop ? mem_q[rd_q] : shift_en ? {1'b0, shift_q[7:1]} : shift_q;
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(push);
    count_d = (push && !pop) ? count_q + (AW+1)'(1) :
              (pop && !push) ? count_q - (AW+1)'(1) : count_q;
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed vector and corner-sequence checks of the buffered UART transmitter
module tb_uart_tx_buffered;
  logic clk, rst, TxD, TxD_busy;
  logic [2:0] fifo_count;
  int total, bad;
  uart_tx_buffered_if bus();
  uart_tx_buffered #(.CLK_FREQ(1000000), .BAUD(100000), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .tx_if(bus),
    .TxD(TxD),
    .TxD_busy(TxD_busy),
    .fifo_count(fifo_count)
  );
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic fbit(input logic [7:0] b, input int n);
    return n == 0 ? 1'b0 : n == 9 ? 1'b1 : b[n-1];
  endfunction
  task automatic push_seq(input logic [7:0] q[$]);
    foreach (q[i]) begin
      bus.tx_valid = 1'b1;
      bus.tx_data = q[i];
      step();
    end
    bus.tx_valid = 1'b0;
  endtask
  task automatic send_check(input logic [7:0] d, input logic [9:0] f, input string tag);
    bus.tx_valid = 1'b1;
    bus.tx_data = d;
    step();
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    chk({tag, "_cnt_acc"}, 32'(fifo_count), 1);
    chk({tag, "_busy_acc"}, 32'(TxD_busy), 1);
    step();
    chk({tag, "_cnt_pop"}, 32'(fifo_count), 0);
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("%s_txd_k%0d", tag, k), 32'(TxD), 32'(f[k/10]));
      step();
    end
    chk({tag, "_busy_end"}, 32'(TxD_busy), 0);
    chk({tag, "_txd_end"}, 32'(TxD), 1);
  endtask
  task automatic check_stream(input logic [7:0] q[$], input int k0, input string tag);
    int busy_low;
    busy_low = 0;
    for (int k = k0; k < 100 * q.size(); k++) begin
      chk($sformatf("%s_txd_k%0d", tag, k), 32'(TxD), 32'(fbit(q[k/100], (k%100)/10)));
      if (!TxD_busy) busy_low++;
      step();
    end
    chk({tag, "_busy_gaps"}, busy_low, 0);
    chk({tag, "_busy_end"}, 32'(TxD_busy), 0);
    chk({tag, "_txd_end"}, 32'(TxD), 1);
    chk({tag, "_cnt_end"}, 32'(fifo_count), 0);
  endtask
  initial begin
    logic [7:0] q[$];
    int k;
    total = 0;
    bad = 0;
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h3C, 10'h278};
    vecs[4] = '{8'h81, 10'h302};
    rst = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) step();
    chk("rst_txd", 32'(TxD), 1);
    chk("rst_busy", 32'(TxD_busy), 0);
    chk("rst_ready", 32'(bus.tx_ready), 1);
    chk("rst_cnt", 32'(fifo_count), 0);
    rst = 1'b0;
    step();
    foreach (vecs[i]) send_check(vecs[i].data, vecs[i].frame, $sformatf("vec%0d", i));
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_seq(q);
    chk("burst_cnt_full", 32'(fifo_count), 4);
    chk("burst_ready_low", 32'(bus.tx_ready), 0);
    check_stream(q, 3, "burst");
    q = '{8'h11, 8'h22, 8'h33};
    push_seq(q);
    chk("pp_cnt_pre", 32'(fifo_count), 2);
    repeat (98) step();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h44;
    step();
    bus.tx_valid = 1'b0;
    chk("pp_cnt_same", 32'(fifo_count), 2);
    chk("pp_txd_start", 32'(TxD), 0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_stream(q, 100, "pushpop");
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push_seq(q);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h77;
    chk("full_ready_low", 32'(bus.tx_ready), 0);
    k = 3;
    while (!bus.tx_ready && k < 200) begin
      step();
      k++;
    end
    chk("full_ready_rise_k", k, 100);
    step();
    k++;
    bus.tx_valid = 1'b0;
    chk("full_cnt_after", 32'(fifo_count), 4);
    chk("full_ready_after", 32'(bus.tx_ready), 0);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h77};
    check_stream(q, k, "full");
    q = '{8'h0F, 8'hAA, 8'hBB};
    push_seq(q);
    chk("mid_cnt_pre", 32'(fifo_count), 2);
    repeat (44) step();
    chk("mid_busy_pre", 32'(TxD_busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_txd", 32'(TxD), 1);
    chk("mid_cnt", 32'(fifo_count), 0);
    chk("mid_busy", 32'(TxD_busy), 0);
    chk("mid_ready", 32'(bus.tx_ready), 1);
    step();
    chk("mid_idle_txd", 32'(TxD), 1);
    send_check(8'h3C, 10'h278, "after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
